alu_mc: RTL and testbench

- Parametrised, multi-cycle successor to the 16-bit accumulator ALU.
- Keeps the single-cycle accumulator opcode set: add/sub with carry, shifts, logic, compare, flag invert.
- Adds WIDTH generalisation, a synchronous reset, and iterative unsigned multiply/divide with a busy interlock.
- Result high half (MUL) or remainder (DIVU) lands in an extension register, readable through MFH.
- Sits between the instruction decoder (which drives opcode/operand/read/write) and the data bus (accout, tri-stated).

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_muldiv_seq.sv | 115 +++++++++++
 rtl/alu_mc.sv | 171 +++++++++++++++++
 tb/tb_alu_mc.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg - shared definitions for the multi-cycle accumulator ALU.
//   Opcode encodings (5-bit, 5'b00000 = NOP) and the multiply/divide
//   sequencer state encoding.
package alu_pkg;

    localparam logic [4:0] OP_NOP  = 5'b00000;
    localparam logic [4:0] OP_ADD  = 5'b00001;
    localparam logic [4:0] OP_SUB  = 5'b00010;
    localparam logic [4:0] OP_SLA  = 5'b00011;
    localparam logic [4:0] OP_SRA  = 5'b00100;
    localparam logic [4:0] OP_SLL  = 5'b00101;
    localparam logic [4:0] OP_SRL  = 5'b00110;
    localparam logic [4:0] OP_AND  = 5'b00111;
    localparam logic [4:0] OP_OR   = 5'b01000;
    localparam logic [4:0] OP_XOR  = 5'b01001;
    localparam logic [4:0] OP_CL   = 5'b01010;
    localparam logic [4:0] OP_CG   = 5'b01011;
    localparam logic [4:0] OP_CE   = 5'b01100;
    localparam logic [4:0] OP_ADC  = 5'b01101;
    localparam logic [4:0] OP_SBB  = 5'b01110;
    localparam logic [4:0] OP_NOTF = 5'b10000;
    localparam logic [4:0] OP_MUL  = 5'b10001;
    localparam logic [4:0] OP_DIVU = 5'b10010;
    localparam logic [4:0] OP_MFH  = 5'b10011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } fsm_state_e;

endpackage

// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq - iterative unsigned multiply (shift-add) and divide
// (restoring) engine, one iteration per clock, WIDTH iterations per op.
//   clk, rst           : clock, synchronous active-high reset (aborts op)
//   start_mul_i        : latch operands and begin a multiply
//   start_div_i        : latch operands and begin a divide (divisor != 0)
//   a_i                : multiplier / dividend (accumulator value)
//   b_i                : multiplicand / divisor (operand bus)
//   busy_o             : operation in progress
//   done_o             : the coming edge performs the last iteration
//   div_o              : the running operation is a divide
//   lo_o / hi_o        : result of the current iteration; on done_o these
//                        are product low/high or quotient/remainder
module alu_muldiv_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_mul_i,
    input  logic             start_div_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             div_o,
    output logic [WIDTH-1:0] lo_o,
    output logic [WIDTH-1:0] hi_o
);

    localparam int CW = $clog2(WIDTH) + 1;

    fsm_state_e       state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] hi_q;     // partial product high / running remainder
    logic [WIDTH-1:0] lo_q;     // multiplier shifting out / quotient shifting in
    logic [WIDTH-1:0] b_q;      // multiplicand / divisor

    logic [WIDTH:0]   add_s;
    logic [WIDTH:0]   rem_sh_s;
    logic [WIDTH-1:0] step_hi_s;
    logic [WIDTH-1:0] step_lo_s;

    // One iteration of the active algorithm, evaluated from the current state
    always_comb begin
        add_s     = {(WIDTH+1){1'b0}};
        rem_sh_s  = {hi_q, lo_q[WIDTH-1]};
        step_hi_s = hi_q;
        step_lo_s = lo_q;
        if (state_q == DIV) begin
            // Remainder stays below the divisor, so WIDTH+1 bits hold the shift
            if (rem_sh_s >= {1'b0, b_q}) begin
                add_s     = rem_sh_s - {1'b0, b_q};
                step_hi_s = add_s[WIDTH-1:0];
                step_lo_s = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                step_hi_s = rem_sh_s[WIDTH-1:0];
                step_lo_s = {lo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            // Add multiplicand on a set LSB, then shift the 2*WIDTH pair right
            add_s     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
            step_hi_s = add_s[WIDTH:1];
            step_lo_s = {add_s[0], lo_q[WIDTH-1:1]};
        end
    end

    assign busy_o = (state_q != IDLE);
    assign done_o = (state_q != IDLE) && (cnt_q == CW'(WIDTH - 1));
    assign div_o  = (state_q == DIV);
    assign lo_o   = step_lo_s;
    assign hi_o   = step_hi_s;

    // Sequencer state, iteration counter and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= {CW{1'b0}};
            hi_q    <= {WIDTH{1'b0}};
            lo_q    <= {WIDTH{1'b0}};
            b_q     <= {WIDTH{1'b0}};
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_q <= {CW{1'b0}};
                    hi_q  <= {WIDTH{1'b0}};
                    lo_q  <= a_i;
                    b_q   <= b_i;
                    if (start_mul_i) begin
                        state_q <= MUL;
                    end else if (start_div_i) begin
                        state_q <= DIV;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                MUL, DIV: begin
                    hi_q <= step_hi_s;
                    lo_q <= step_lo_s;
                    if (done_o) begin
                        state_q <= IDLE;
                        cnt_q   <= {CW{1'b0}};
                    end else begin
                        cnt_q   <= cnt_q + {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= {CW{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: rtl/alu_mc.sv
// alu_mc - parametrised multi-cycle accumulator ALU.
//   clk, rst : clock, synchronous active-high reset
//   opcode   : operation select (5'b00000 = NOP)
//   operand  : second operand / write data / shift amount
//   read     : drive accout with acc, else high-Z
//   write    : load acc from operand (NOP cycles only)
//   writeu   : load upper UPPER_BITS of acc from operand[UPPER_BITS-1:0]
//   accout   : accumulator output (tri-stated)
//   flag     : compare / divide-by-zero flag
//   carry    : carry / borrow bit
//   busy     : multiply or divide in progress; all commands ignored
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int UPPER_BITS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       opcode,
    input  logic [WIDTH-1:0] operand,
    input  logic             read,
    input  logic             write,
    input  logic             writeu,
    output logic [WIDTH-1:0] accout,
    output logic             flag,
    output logic             carry,
    output logic             busy
);

    logic [WIDTH-1:0] acc_q,   acc_d;
    logic [WIDTH-1:0] ext_q,   ext_d;
    logic             carry_q, carry_d;
    logic             flag_q,  flag_d;

    logic [WIDTH:0]   sum_s;
    logic [WIDTH-1:0] wr_val_s;
    logic             start_mul_s;
    logic             start_div_s;
    logic             md_busy_s;
    logic             md_done_s;
    logic             md_div_s;
    logic [WIDTH-1:0] md_lo_s;
    logic [WIDTH-1:0] md_hi_s;

    alu_muldiv_seq #(.WIDTH(WIDTH)) u_muldiv (
        .clk         (clk),
        .rst         (rst),
        .start_mul_i (start_mul_s),
        .start_div_i (start_div_s),
        .a_i         (acc_q),
        .b_i         (operand),
        .busy_o      (md_busy_s),
        .done_o      (md_done_s),
        .div_o       (md_div_s),
        .lo_o        (md_lo_s),
        .hi_o        (md_hi_s)
    );

    // Write path on NOP cycles: write first, writeu overlays the upper field
    always_comb begin
        wr_val_s = write ? operand : acc_q;
        wr_val_s[WIDTH-1 -: UPPER_BITS] = writeu ? operand[UPPER_BITS-1:0]
                                                 : wr_val_s[WIDTH-1 -: UPPER_BITS];
    end

    // Next-state for the architectural registers
    always_comb begin
        acc_d       = acc_q;
        ext_d       = ext_q;
        carry_d     = carry_q;
        flag_d      = flag_q;
        sum_s       = {(WIDTH+1){1'b0}};
        start_mul_s = 1'b0;
        start_div_s = 1'b0;
        if (md_done_s) begin
            acc_d = md_lo_s;
            ext_d = md_hi_s;
            if (md_div_s) begin
                flag_d  = 1'b0;
                carry_d = 1'b0;
            end else begin
                carry_d = |md_hi_s;
            end
        end else if (!md_busy_s) begin
            case (opcode)
                OP_ADD: begin
                    sum_s = {1'b0, acc_q} + {1'b0, operand};
                    {carry_d, acc_d} = sum_s;
                end
                OP_ADC: begin
                    sum_s = {1'b0, acc_q} + {1'b0, operand} + {{WIDTH{1'b0}}, carry_q};
                    {carry_d, acc_d} = sum_s;
                end
                // Bit WIDTH of the wrapped difference is the borrow
                OP_SUB: begin
                    sum_s = {1'b0, acc_q} - {1'b0, operand};
                    {carry_d, acc_d} = sum_s;
                end
                OP_SBB: begin
                    sum_s = {1'b0, acc_q} - {1'b0, operand} - {{WIDTH{1'b0}}, carry_q};
                    {carry_d, acc_d} = sum_s;
                end
                // Shifts use the whole operand; oversized amounts flush naturally
                OP_SLA, OP_SLL: begin
                    acc_d   = acc_q << operand;
                    carry_d = 1'b0;
                end
                OP_SRA: begin
                    acc_d   = $signed(acc_q) >>> operand;
                    carry_d = 1'b0;
                end
                OP_SRL: begin
                    acc_d   = acc_q >> operand;
                    carry_d = 1'b0;
                end
                OP_AND: begin
                    acc_d   = acc_q & operand;
                    carry_d = 1'b0;
                end
                OP_OR: begin
                    acc_d   = acc_q | operand;
                    carry_d = 1'b0;
                end
                OP_XOR: begin
                    acc_d   = acc_q ^ operand;
                    carry_d = 1'b0;
                end
                OP_CL:   flag_d = ($signed(acc_q) < $signed(operand));
                OP_CG:   flag_d = ($signed(acc_q) > $signed(operand));
                OP_CE:   flag_d = (acc_q == operand);
                OP_NOTF: flag_d = ~flag_q;
                OP_MFH:  acc_d  = ext_q;
                OP_MUL:  start_mul_s = 1'b1;
                OP_DIVU: begin
                    // Zero divisor is resolved immediately without entering busy
                    if (operand == {WIDTH{1'b0}}) begin
                        flag_d = 1'b1;
                        ext_d  = acc_q;
                    end else begin
                        start_div_s = 1'b1;
                    end
                end
                default: acc_d = wr_val_s;   // NOP and unused opcodes
            endcase
        end else begin
            acc_d = acc_q;                   // busy: hold, partial result hidden
        end
    end

    // Architectural register update
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q   <= {WIDTH{1'b0}};
            ext_q   <= {WIDTH{1'b0}};
            carry_q <= 1'b0;
            flag_q  <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            ext_q   <= ext_d;
            carry_q <= carry_d;
            flag_q  <= flag_d;
        end
    end

    assign accout = read ? acc_q : {WIDTH{1'bz}};
    assign flag   = flag_q;
    assign carry  = carry_q;
    assign busy   = md_busy_s;

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc - self-checking bench for alu_mc (WIDTH=16) using a reference
// model that pushes expected results into a scoreboard queue.
module tb_alu_mc;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  opcode;
    logic [15:0] operand;
    logic        read, write, writeu;
    wire  [15:0] accout;
    logic        flag, carry, busy;

    alu_mc #(.WIDTH(16), .UPPER_BITS(4)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .operand(operand),
        .read(read), .write(write), .writeu(writeu),
        .accout(accout), .flag(flag), .carry(carry), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [15:0] acc;
        logic        carry;
        logic        flag;
    } exp_t;

    exp_t        sb_q[$];
    int          n_pass  = 0;
    int          n_total = 0;
    logic [15:0] m_acc, m_ext;
    logic        m_carry, m_flag;

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_acc = 16'h0000; m_ext = 16'h0000; m_carry = 1'b0; m_flag = 1'b0;
    endtask

    // Behavioural reference of one accepted command
    task automatic model_op(input logic [4:0] op, input logic [15:0] b,
                            input logic wr, input logic wu);
        longint t;
        int a_s, b_s;
        logic signed [15:0] sa;
        logic [15:0] q, r;
        a_s = m_acc[15] ? int'(m_acc) - 65536 : int'(m_acc);
        b_s = b[15]     ? int'(b) - 65536     : int'(b);
        case (op)
            OP_ADD: begin t = longint'(m_acc) + longint'(b); m_acc = t[15:0]; m_carry = (t > 65535); end
            OP_ADC: begin t = longint'(m_acc) + longint'(b) + longint'(m_carry); m_acc = t[15:0]; m_carry = (t > 65535); end
            OP_SUB: begin t = longint'(m_acc) - longint'(b); m_acc = t[15:0]; m_carry = (t < 0); end
            OP_SBB: begin t = longint'(m_acc) - longint'(b) - longint'(m_carry); m_acc = t[15:0]; m_carry = (t < 0); end
            OP_SLA, OP_SLL: begin m_acc = (b >= 16'd16) ? 16'h0000 : (m_acc << b); m_carry = 1'b0; end
            OP_SRL: begin m_acc = (b >= 16'd16) ? 16'h0000 : (m_acc >> b); m_carry = 1'b0; end
            OP_SRA: begin
                sa = m_acc;
                if (b >= 16'd16) m_acc = {16{m_acc[15]}};
                else             m_acc = sa >>> b;
                m_carry = 1'b0;
            end
            OP_AND:  begin m_acc = m_acc & b; m_carry = 1'b0; end
            OP_OR:   begin m_acc = m_acc | b; m_carry = 1'b0; end
            OP_XOR:  begin m_acc = m_acc ^ b; m_carry = 1'b0; end
            OP_CL:   m_flag = (a_s < b_s);
            OP_CG:   m_flag = (a_s > b_s);
            OP_CE:   m_flag = (m_acc == b);
            OP_NOTF: m_flag = ~m_flag;
            OP_MFH:  m_acc = m_ext;
            OP_MUL: begin
                t = longint'(m_acc) * longint'(b);
                m_acc = t[15:0]; m_ext = t[31:16]; m_carry = (m_ext != 16'h0000);
            end
            OP_DIVU: begin
                if (b == 16'h0000) begin
                    m_flag = 1'b1; m_ext = m_acc;
                end else begin
                    q = m_acc / b; r = m_acc % b;
                    m_acc = q; m_ext = r; m_flag = 1'b0; m_carry = 1'b0;
                end
            end
            default: begin
                if (wr) m_acc = b;
                if (wu) m_acc[15:12] = b[3:0];
            end
        endcase
    endtask

    task automatic push_exp(input string tag);
        exp_t e;
        e.tag = tag; e.acc = m_acc; e.carry = m_carry; e.flag = m_flag;
        sb_q.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb_q.size() == 0) begin
            n_total++;
            $display("FAIL scoreboard: got empty queue, expected an entry");
        end else begin
            e = sb_q.pop_front();
            check_val({e.tag, ".acc"},   accout,       e.acc);
            check_val({e.tag, ".carry"}, 16'(carry),   16'(e.carry));
            check_val({e.tag, ".flag"},  16'(flag),    16'(e.flag));
            check_val({e.tag, ".busy"},  16'(busy),    16'h0000);
        end
    endtask

    task automatic idle_inputs();
        opcode = OP_NOP; operand = 16'h0000; write = 1'b0; writeu = 1'b0;
    endtask

    // Single-cycle command: drive, model, one edge, compare
    task automatic do_op(input string tag, input logic [4:0] op, input logic [15:0] b,
                         input logic wr, input logic wu);
        opcode = op; operand = b; write = wr; writeu = wu;
        model_op(op, b, wr, wu);
        push_exp(tag);
        @(posedge clk); #1;
        idle_inputs();
        pop_check();
    endtask

    // Multi-cycle command; optionally hammers ADD+write while busy
    task automatic do_md(input string tag, input logic [4:0] op, input logic [15:0] b,
                         input logic inject);
        logic [15:0] old_acc;
        int cyc;
        old_acc = m_acc;
        opcode = op; operand = b; write = 1'b0; writeu = 1'b0;
        model_op(op, b, 1'b0, 1'b0);
        push_exp(tag);
        @(posedge clk); #1;
        check_val({tag, ".hold"}, accout, old_acc);
        opcode  = inject ? OP_ADD : OP_NOP;
        operand = 16'h0001;
        write   = inject;
        cyc = 0;
        while (busy === 1'b1 && cyc < 40) begin
            cyc++;
            @(posedge clk); #1;
        end
        idle_inputs();
        check_val({tag, ".busy_cycles"}, 16'(cyc), 16'd16);
        pop_check();
    endtask

    logic [4:0] ops [0:21] = '{OP_NOP, OP_ADD, OP_SUB, OP_SLA, OP_SRA, OP_SLL, OP_SRL,
                               OP_AND, OP_OR, OP_XOR, OP_CL, OP_CG, OP_CE, OP_ADC,
                               OP_SBB, OP_NOTF, OP_MUL, OP_DIVU, OP_MFH,
                               5'b01111, 5'b10100, 5'b11111};

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic [4:0]  op;
        logic [15:0] b;
        logic        hz_ok;
        rst = 1'b1; read = 1'b1; idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        check_val("reset.acc",   accout,     16'h0000);
        check_val("reset.carry", 16'(carry), 16'h0000);
        check_val("reset.flag",  16'(flag),  16'h0000);
        check_val("reset.busy",  16'(busy),  16'h0000);

        // Add / add-with-carry wrap
        do_op("wr_ffff", OP_NOP, 16'hFFFF, 1'b1, 1'b0);
        do_op("add_wrap", OP_ADD, 16'h0001, 1'b0, 1'b0);
        check_val("plan.add_acc",   accout,     16'h0000);
        check_val("plan.add_carry", 16'(carry), 16'h0001);
        do_op("adc", OP_ADC, 16'h0000, 1'b0, 1'b0);
        check_val("plan.adc_acc", accout, 16'h0001);

        // Signed compares and flag invert
        do_op("wr_8000", OP_NOP, 16'h8000, 1'b1, 1'b0);
        do_op("cl", OP_CL, 16'h0001, 1'b0, 1'b0);
        check_val("plan.cl_flag", 16'(flag), 16'h0001);
        do_op("cg", OP_CG, 16'h7FFF, 1'b0, 1'b0);
        do_op("notf", OP_NOTF, 16'h0000, 1'b0, 1'b0);
        do_op("ce", OP_CE, 16'h8000, 1'b0, 1'b0);

        // Multiply with commands hammered while busy
        do_op("wr_1234", OP_NOP, 16'h1234, 1'b1, 1'b0);
        do_md("mul", OP_MUL, 16'h0100, 1'b1);
        check_val("plan.mul_acc", accout, 16'h3400);
        do_op("mfh_mul", OP_MFH, 16'h0000, 1'b0, 1'b0);
        check_val("plan.mfh_mul", accout, 16'h0012);

        // Divide
        do_op("wr_100", OP_NOP, 16'h0064, 1'b1, 1'b0);
        do_md("divu", OP_DIVU, 16'h0007, 1'b0);
        check_val("plan.div_q", accout, 16'h000E);
        do_op("mfh_div", OP_MFH, 16'h0000, 1'b0, 1'b0);
        check_val("plan.div_r", accout, 16'h0002);

        // Divide by zero: never busy
        do_op("wr_55", OP_NOP, 16'h0055, 1'b1, 1'b0);
        do_op("div0", OP_DIVU, 16'h0000, 1'b0, 1'b0);
        check_val("plan.div0_flag", 16'(flag), 16'h0001);
        do_op("mfh_div0", OP_MFH, 16'h0000, 1'b0, 1'b0);

        // Write / writeu priority and tri-state output
        do_op("wr_0abc", OP_NOP, 16'h0ABC, 1'b1, 1'b0);
        do_op("wu_5", OP_NOP, 16'h0005, 1'b0, 1'b1);
        check_val("plan.writeu", accout, 16'h5ABC);
        do_op("wr_wu", OP_NOP, 16'h0AB5, 1'b1, 1'b1);
        do_op("op_over_wr", OP_XOR, 16'h00FF, 1'b1, 1'b1);
        read = 1'b0;
        #1;
        hz_ok = (accout !== m_acc);
        check_val("hiz", 16'(hz_ok), 16'h0001);
        read = 1'b1;

        // Oversized arithmetic shift clears carry
        do_op("wr_ffff2", OP_NOP, 16'hFFFF, 1'b1, 1'b0);
        do_op("add_c", OP_ADD, 16'h0001, 1'b0, 1'b0);
        do_op("wr_8000b", OP_NOP, 16'h8000, 1'b1, 1'b0);
        do_op("sra20", OP_SRA, 16'd20, 1'b0, 1'b0);
        check_val("plan.sra20", accout, 16'hFFFF);
        do_op("wr_8000c", OP_NOP, 16'h8000, 1'b1, 1'b0);
        do_op("srl3", OP_SRL, 16'd3, 1'b0, 1'b0);
        do_op("sll16", OP_SLL, 16'd16, 1'b0, 1'b0);

        // Reset mid-multiply aborts everything
        do_op("wr_7777", OP_NOP, 16'h7777, 1'b1, 1'b0);
        do_op("notf_r", OP_NOTF, 16'h0000, 1'b0, 1'b0);
        opcode = OP_MUL; operand = 16'h0003;
        @(posedge clk); #1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        check_val("rst_mid.busy",  16'(busy),  16'h0000);
        check_val("rst_mid.acc",   accout,     16'h0000);
        check_val("rst_mid.carry", 16'(carry), 16'h0000);
        check_val("rst_mid.flag",  16'(flag),  16'h0000);
        do_op("rst_mid.mfh", OP_MFH, 16'h0000, 1'b0, 1'b0);

        // Random mix against the model
        for (int i = 0; i < 60; i++) begin
            op = ops[$urandom_range(0, 21)];
            b  = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 20)) : 16'($urandom);
            if (op == OP_MUL || (op == OP_DIVU && b != 16'h0000))
                do_md($sformatf("rnd%0d", i), op, b, 1'($urandom_range(0, 1)));
            else
                do_op($sformatf("rnd%0d", i), op, b, 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
